// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle adder/subtractor. Each operation is split into N = WIDTH/CHUNK
//   slices that are added LSB first, one slice per clock, with the carry
//   carried between cycles in a register. Subtraction is done as
//   a + ~b + ~ci, so cout=1 means "no borrow".
//
// Parameters
//   WIDTH  operand / result width (must be a multiple of CHUNK)
//   CHUNK  bits added per clock
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous, active-high reset
//   start  begin an operation on the current a, b, ci, sub (ignored while busy)
//   a, b   operands
//   ci     carry-in (add) / borrow-in (subtract)
//   sub    0 = add, 1 = subtract
//   busy   high while slices are being added
//   done   one-cycle pulse, sum/cout/ovf newly updated
//   sum    registered result, held until the next completion
//   cout   raw carry out of the MSB
//   ovf    two's-complement overflow
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    // Index register is at least one bit wide so N=1 still elaborates.
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;      // latched A
    logic [WIDTH-1:0] b_q;      // latched B, already inverted for subtract
    logic [WIDTH-1:0] part_q;   // slices finished so far; never visible on sum
    logic             carry_q;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] part_next;
    logic             ovf_next;

    // Slice adder for the current index, plus the full word as it will look
    // once this slice is merged in (used as the final sum on the last slice).
    always_comb begin
        a_chunk   = a_q[idx*CHUNK +: CHUNK];
        b_chunk   = b_q[idx*CHUNK +: CHUNK];
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
        part_next = part_q;
        part_next[idx*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        // Overflow: both effective operands share a sign that the result lacks.
        ovf_next  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (part_next[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                // DONE accepts start exactly like IDLE, which gives
                // back-to-back operations with no idle cycle in between.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= ci ^ sub;
                        part_q  <= '0;
                        idx     <= '0;
                        state   <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end

                RUN: begin
                    part_q  <= part_next;
                    carry_q <= chunk_res[CHUNK];
                    if (idx == LAST) begin
                        // Last slice: publish the whole result at once.
                        sum   <= part_next;
                        cout  <= chunk_res[CHUNK];
                        ovf   <= ovf_next;
                        idx   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + IW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
